decimation_avg_multich: RTL and testbench
=========================================

// Module: decimation_avg_multich
// PURPOSE
// Parametrised successor to the fixed two-channel decimator. NofCh channels, each delivering
// two samples per clock (x = older, xz = newer), are decimated by runtime-selectable 2^k
// (k = 0..MaxLog2) using a rounded boxcar average. Output keeps the two-samples-per-word
// format for the LVDS/host path. Adds a runtime ramp test source and a clean restart on
// ratio change. Sits between the ADC capture front-end and the LVDS/record path.
// PARAMETERS
// NofBits  16  sample width, signed two's complement
// NofCh    2   number of channels
// MaxLog2  10  largest supported log2 decimation factor
// PORTS
// clk_i         in   1               sample clock; all logic in this domain
// rst_i         in   1               asynchronous, active-low reset
// decim_ctrl_i  in   4               k = log2 decimation; values > MaxLog2 clamp to MaxLog2
// test_ctrl_i   in   1               1 = replace ADC data with internal ramp
// x_i           in   NofCh*NofBits   older sample per channel, ch c at [c*NofBits +: NofBits]
// xz_i          in   NofCh*NofBits   newer sample per channel, same packing
// y_o           out  NofCh*NofBits   older decimated result per channel
// yz_o          out  NofCh*NofBits   newer decimated result per channel
// data_valid_o  out  1               one-cycle strobe: y_o/yz_o hold a new word
// BEHAVIOUR
// - Reset (rst_i=0, async): y_o, yz_o, data_valid_o = 0; accumulators, phase counter,
//   pair flag and ramp = 0; k register = 0. Reset is async assert, sync release.
// - Input stage: x_i/xz_i (or ramp) registered each clock. Sample order per channel: x then xz.
// - k=0 bypass: y_o<=x, yz_o<=xz; data_valid_o=1 every clock; latency 2 clk input->output.
// - k>=1: per channel, sum the 2^k consecutive samples (2^(k-1) clocks of x+xz) in a signed
//   accumulator of NofBits+MaxLog2+1 bits. Result r = (sum + 2^(k-1)) >>> k
//   (arithmetic shift, round half up). No saturation needed; result always fits NofBits.
// - Pairing: results r0,r1,r2,...; y_o=r(2m), yz_o=r(2m+1); data_valid_o pulses with the
//   word when r(2m+1) is complete -> exactly one strobe per 2^k clocks, outputs held between
//   strobes. Latency: last contributing sample's input edge +2 clk to strobe.
// - All channels share one phase counter -> channels always aligned, same strobe.
// - Ratio change: decim_ctrl_i (clamped) registered every clock; a value differing from the
//   active k causes a restart next clock: accumulators, phase, pair flag cleared, partial
//   data discarded, no strobe for the aborted period; outputs hold last word. First strobe
//   after restart: 2^k clocks of new data + latency.
// - Test mode: ramp counter R (NofBits, wraps) increments by 2 each clock; every channel
//   gets x=R, xz=R+1 (modulo 2^NofBits). test_ctrl_i switching does NOT restart decimation;
//   the mixed window is averaged as-is.
// - Accumulator wrap cannot occur for k<=MaxLog2 (width covers 2^MaxLog2 full-scale samples).
// TESTING
// 1 k=0, x=100,xz=-100 on all ch -> from clk 2: y=100,yz=-100, data_valid_o high every clk.
// 2 k=2, ch0 samples 1,2,3,4,5,6,7,8 -> one strobe per 4 clk; y=3 (2.5 rounds up), yz=7.
// 3 k=1, x=-3,xz=-2 -> r=(-5+1)>>>1=-2; y=yz=-2; round-half-up on negatives checked.
// 4 k=10 all samples 32767 then all -32768 -> y=yz=32767, next word -32768; strobe every 1024 clk.
// 5 k=3 running, switch to k=2 mid-window -> no strobe for partial window; first strobe 4 clk
//   + latency after change; outputs held meanwhile. Also decim_ctrl_i=15 behaves as k=10.
// 6 test_ctrl_i=1, k=1 -> results R+0.5 round: y=2n+1, yz=2n+3 sequence on every channel;
//   rst_i low mid-window -> all outputs 0 immediately, restart clean after release.

Source files
------------

// File: rtl/decimation_avg_multich.sv
// Multi-channel 2^k boxcar decimator with round-half-up averaging, runtime ratio
// selection with clean restart, and an internal ramp test source.
module decimation_avg_multich #(
    parameter int NofBits = 16,
    parameter int NofCh   = 2,
    parameter int MaxLog2 = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [3:0]               decim_ctrl_i,
    input  logic                     test_ctrl_i,
    input  logic [NofCh*NofBits-1:0] x_i,
    input  logic [NofCh*NofBits-1:0] xz_i,
    output logic [NofCh*NofBits-1:0] y_o,
    output logic [NofCh*NofBits-1:0] yz_o,
    output logic                     data_valid_o
);

    localparam int AccW = NofBits + MaxLog2 + 1;
    localparam int KW   = $clog2(MaxLog2 + 1);
    localparam int PW   = MaxLog2;

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    // NOTE: every clocked register uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [3:0]    k_clamp4;
    logic [KW-1:0] k_clamp;

    assign k_clamp4 = (decim_ctrl_i > 4'(MaxLog2)) ? 4'(MaxLog2) : decim_ctrl_i;
    assign k_clamp  = KW'(k_clamp4);

    // Input stage: ADC samples or ramp, plus requested ratio.
    logic        [NofBits-1:0] ramp;
    logic signed [NofBits-1:0] x_r  [NofCh];
    logic signed [NofBits-1:0] xz_r [NofCh];
    logic                      in_vld;
    logic        [KW-1:0]      k_req;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ramp   <= '0;
            in_vld <= 1'b0;
            k_req  <= '0;
            // NOTE: these per-channel arrays are a few registers, not RAM, so resetting them is cheap and keeps restart deterministic.
            for (int c = 0; c < NofCh; c++) begin
                x_r[c]  <= '0;
                xz_r[c] <= '0;
            end
        end else begin
            ramp   <= ramp + NofBits'(2);
            in_vld <= 1'b1;
            k_req  <= k_clamp;
            for (int c = 0; c < NofCh; c++) begin
                if (test_ctrl_i) begin
                    x_r[c]  <= ramp;
                    xz_r[c] <= ramp + NofBits'(1);
                end else begin
                    x_r[c]  <= x_i[c*NofBits +: NofBits];
                    xz_r[c] <= xz_i[c*NofBits +: NofBits];
                end
            end
        end
    end

    // Decimation state shared by all channels.
    logic        [KW-1:0]      k_act;
    logic        [PW-1:0]      phase;
    logic                      pair;
    logic signed [AccW-1:0]    acc    [NofCh];
    logic signed [NofBits-1:0] r_even [NofCh];

    logic signed [AccW-1:0]    sum [NofCh];
    logic signed [NofBits-1:0] res [NofCh];
    logic signed [AccW-1:0]    round_k;
    logic                      ph_last;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        round_k = AccW'(1) << (k_act - KW'(1));
        ph_last = (phase == ((PW'(1) << (k_act - KW'(1))) - PW'(1)));
        for (int c = 0; c < NofCh; c++) begin
            sum[c] = acc[c] + AccW'(x_r[c]) + AccW'(xz_r[c]);
            // Signed operands keep >>> arithmetic, giving round-half-up.
            res[c] = NofBits'((sum[c] + round_k) >>> k_act);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            k_act        <= '0;
            phase        <= '0;
            pair         <= 1'b0;
            y_o          <= '0;
            yz_o         <= '0;
            data_valid_o <= 1'b0;
            for (int c = 0; c < NofCh; c++) begin
                acc[c]    <= '0;
                r_even[c] <= '0;
            end
        end else begin
            data_valid_o <= 1'b0;
            if (k_req != k_act) begin
                // Ratio change: drop partial window, outputs keep the last word.
                k_act <= k_req;
                phase <= '0;
                pair  <= 1'b0;
                for (int c = 0; c < NofCh; c++) begin
                    acc[c] <= '0;
                end
            end else if (in_vld) begin
                if (k_act == '0) begin
                    data_valid_o <= 1'b1;
                    for (int c = 0; c < NofCh; c++) begin
                        y_o[c*NofBits +: NofBits]  <= x_r[c];
                        yz_o[c*NofBits +: NofBits] <= xz_r[c];
                    end
                end else if (ph_last) begin
                    phase <= '0;
                    for (int c = 0; c < NofCh; c++) begin
                        acc[c] <= '0;
                    end
                    if (!pair) begin
                        pair <= 1'b1;
                        for (int c = 0; c < NofCh; c++) begin
                            r_even[c] <= res[c];
                        end
                    end else begin
                        pair         <= 1'b0;
                        data_valid_o <= 1'b1;
                        for (int c = 0; c < NofCh; c++) begin
                            y_o[c*NofBits +: NofBits]  <= r_even[c];
                            yz_o[c*NofBits +: NofBits] <= res[c];
                        end
                    end
                end else begin
                    phase <= phase + PW'(1);
                    for (int c = 0; c < NofCh; c++) begin
                        acc[c] <= sum[c];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decimation_avg_multich.sv
// Bench for decimation_avg_multich: vector table plus hand sequences, checked
// through a scoreboard queue filled as stimulus is driven.
module tb_decimation_avg_multich;

    localparam int NB  = 16;
    localparam int NCH = 2;
    localparam int ML  = 10;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic [3:0]        decim_ctrl_i = 4'd10;
    logic              test_ctrl_i = 1'b0;
    logic [NCH*NB-1:0] x_i = '0;
    logic [NCH*NB-1:0] xz_i = '0;
    logic [NCH*NB-1:0] y_o;
    logic [NCH*NB-1:0] yz_o;
    logic              data_valid_o;

    decimation_avg_multich #(.NofBits(NB), .NofCh(NCH), .MaxLog2(ML)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .decim_ctrl_i (decim_ctrl_i),
        .test_ctrl_i  (test_ctrl_i),
        .x_i          (x_i),
        .xz_i         (xz_i),
        .y_o          (y_o),
        .yz_o         (yz_o),
        .data_valid_o (data_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y  [NCH];
        int yz [NCH];
    } word_t;

    typedef struct {
        int k;
        int x0;
        int xz0;
        int step;
        int nwords;
        int ey0;
        int eyz0;
        int ey1;
        int eyz1;
    } vec_t;

    word_t sb_q[$];
    vec_t  vecs[7];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_k = ML;
    int set_cyc = 0;
    int last_strobe = 0;
    int prev_strobe = 0;
    bit sb_en = 1'b1;
    bit hold_en = 1'b1;
    int last_y  [NCH];
    int last_yz [NCH];
    word_t mon_w;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int chan_val(input int c, input int v, input bit alt);
        logic [NB-1:0] t;
        t = NB'((alt && (c % 2 == 1)) ? -v : v);
        return int'($signed(t));
    endfunction

    function automatic int out_ch(input logic [NCH*NB-1:0] v, input int c);
        logic [NB-1:0] s;
        s = v[c*NB +: NB];
        return int'($signed(s));
    endfunction

    // Reference average: floor((s + d/2) / d) written with explicit floor division.
    function automatic int ref_avg(input longint s, input int k);
        longint d, num, q;
        d   = longint'(1) << k;
        num = s + d / 2;
        q   = num / d;
        if ((num % d != 0) && (num < 0)) q = q - 1;
        return int'(q);
    endfunction

    function automatic int clamp_k(input int k);
        return (k > ML) ? ML : k;
    endfunction

    task automatic drive_clk(input int xv, input int xzv, input bit alt);
        for (int c = 0; c < NCH; c++) begin
            x_i[c*NB +: NB]  = NB'(chan_val(c, xv, alt));
            xz_i[c*NB +: NB] = NB'(chan_val(c, xzv, alt));
        end
        @(posedge clk);
        #1;
    endtask

    // New ratio takes effect after one discarded filler clock.
    task automatic set_k(input int k);
        decim_ctrl_i = 4'(k);
        set_cyc = cyc;
        cur_k = clamp_k(k);
        drive_clk(0, 0, 1'b0);
    endtask

    task automatic run_word(input int k, input int x0, input int xz0, input int step,
                            input bit alt, input bit push);
        int ke, nclk, half, xv, xzv;
        longint s0 [NCH];
        longint s1 [NCH];
        word_t w;
        ke   = clamp_k(k);
        nclk = 1 << ke;
        half = (ke == 0) ? 1 : nclk / 2;
        for (int c = 0; c < NCH; c++) begin
            s0[c] = 0;
            s1[c] = 0;
        end
        for (int t = 0; t < nclk; t++) begin
            xv  = x0 + step * t;
            xzv = xz0 + step * t;
            for (int c = 0; c < NCH; c++) begin
                if (t < half) s0[c] += chan_val(c, xv, alt) + chan_val(c, xzv, alt);
                else          s1[c] += chan_val(c, xv, alt) + chan_val(c, xzv, alt);
            end
            drive_clk(xv, xzv, alt);
        end
        if (push) begin
            for (int c = 0; c < NCH; c++) begin
                if (ke == 0) begin
                    w.y[c]  = chan_val(c, x0, alt);
                    w.yz[c] = chan_val(c, xz0, alt);
                end else begin
                    w.y[c]  = ref_avg(s0[c], ke);
                    w.yz[c] = ref_avg(s1[c], ke);
                end
            end
            sb_q.push_back(w);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({"drain_", tag}, sb_q.size(), 0);
    endtask

    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (data_valid_o) ok = 1'b1;
        end
    endtask

    // Ramp at k=1: y = 2n+1, yz = y+2, successive words step by 4, channels equal.
    task automatic ramp_words(input int n, input int first_budget);
        bit ok;
        int y0, prev;
        prev = 0;
        for (int i = 0; i < n; i++) begin
            wait_strobe((i == 0) ? first_budget : 4, ok);
            check("ramp_strobe_seen", int'(ok), 1);
            if (ok) begin
                y0 = out_ch(y_o, 0);
                check("ramp_y_odd", y0 & 1, 1);
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("ramp_pair_ch%0d", c),
                          (out_ch(yz_o, c) - out_ch(y_o, c)) & 16'hFFFF, 2);
                    if (c > 0) check($sformatf("ramp_ch_eq%0d", c), out_ch(y_o, c), y0);
                end
                if (i > 0) check("ramp_step", (y0 - prev) & 16'hFFFF, 4);
                prev = y0;
            end
        end
    endtask

    // Scoreboard pop on each strobe; outputs must hold between strobes.
    always @(negedge clk) begin
        if (rst_i) begin
            if (data_valid_o) begin
                prev_strobe = last_strobe;
                last_strobe = cyc;
                if (sb_en) begin
                    check("sb_nonempty", int'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        mon_w = sb_q.pop_front();
                        for (int c = 0; c < NCH; c++) begin
                            check($sformatf("y_ch%0d", c), out_ch(y_o, c), mon_w.y[c]);
                            check($sformatf("yz_ch%0d", c), out_ch(yz_o, c), mon_w.yz[c]);
                        end
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    last_y[c]  = out_ch(y_o, c);
                    last_yz[c] = out_ch(yz_o, c);
                end
            end else if (hold_en) begin
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("hold_y_ch%0d", c), out_ch(y_o, c), last_y[c]);
                    check($sformatf("hold_yz_ch%0d", c), out_ch(yz_o, c), last_yz[c]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            last_y[c]  = 0;
            last_yz[c] = 0;
        end
        //           k  x0      xz0     step nw  ey0    eyz0    ey1     eyz1
        vecs[0] = '{0, 100,    -100,   0,   3,  100,   -100,   -100,   100};
        vecs[1] = '{0, 32767,  -32767, 0,   2,  32767, -32767, -32767, 32767};
        vecs[2] = '{2, 1,      2,      2,   1,  3,     7,      -2,     -6};
        vecs[3] = '{1, -3,     -2,     0,   2,  -2,    -2,     3,      3};
        vecs[4] = '{1, 0,      1,      0,   1,  1,     1,      0,      0};
        vecs[5] = '{3, 10,     11,     2,   1,  14,    22,     -13,    -21};
        vecs[6] = '{2, -1,     0,      0,   1,  0,     0,      1,      1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_y", int'(y_o), 0);
        check("rst_yz", int'(yz_o), 0);
        check("rst_valid", int'(data_valid_o), 0);
        rst_i = 1'b1;
        repeat (6) drive_clk(0, 0, 1'b0);

        // Vector table
        for (int r = 0; r < 7; r++) begin
            word_t w;
            if (clamp_k(vecs[r].k) != cur_k) set_k(vecs[r].k);
            for (int n = 0; n < vecs[r].nwords; n++) begin
                run_word(vecs[r].k, vecs[r].x0, vecs[r].xz0, vecs[r].step, 1'b1, 1'b0);
                for (int c = 0; c < NCH; c++) begin
                    w.y[c]  = (c % 2 == 0) ? vecs[r].ey0  : vecs[r].ey1;
                    w.yz[c] = (c % 2 == 0) ? vecs[r].eyz0 : vecs[r].eyz1;
                end
                sb_q.push_back(w);
            end
        end
        drain("table", 20);

        // Ratio change mid-window: partial data discarded, clean k=2 window follows
        set_k(3);
        run_word(3, 5, 5, 0, 1'b1, 1'b1);
        for (int t = 0; t < 5; t++) drive_clk(77, -33, 1'b1);
        set_k(2);
        run_word(2, 9, 9, 0, 1'b1, 1'b1);
        drain("restart", 20);
        check("restart_latency", last_strobe - set_cyc, 6);

        // Full-scale at k=10, then ctrl=15 clamps to the same k (no restart)
        set_k(10);
        run_word(10, 32767, 32767, 0, 1'b0, 1'b1);
        decim_ctrl_i = 4'd15;
        run_word(15, -32768, -32768, 0, 1'b0, 1'b1);
        drain("k10", 20);
        check("k10_gap", last_strobe - prev_strobe, 1024);

        // Ramp test source at k=1, then reset in the middle of a window
        sb_en = 1'b0;
        test_ctrl_i = 1'b1;
        set_k(1);
        ramp_words(3, 8);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            last_y[c]  = 0;
            last_yz[c] = 0;
        end
        #1;
        check("midrst_y", int'(y_o), 0);
        check("midrst_yz", int'(yz_o), 0);
        check("midrst_valid", int'(data_valid_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        ramp_words(2, 16);

        @(negedge clk);
        check("sb_final_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
